// File: rtl/ifu_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ifu_fetch_queue                                               |
// | Purpose  : Multi-outstanding instruction fetch unit: issues ICache        |
// |            requests, keeps an in-order PC/data queue and delivers fetch   |
// |            groups to the IBuffer; flush redirects and drops stale data.   |
// |            Optional perf counters: define IFU_FETCH_PERF_EN.              |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module ifu_fetch_queue #(
   parameter int              PLEN            = 32,
   parameter int              ILEN            = 32,
   parameter int              INSTR_PER_FETCH = 4,
   parameter int              MAX_INFLIGHT    = 4,
   parameter logic [PLEN-1:0] RESET_PC        = 32'h8000_0000
) (
   input  logic                            clk,
   input  logic                            rst,
   output logic [PLEN-1:0]                 ifu2bpu_pc_o,
   input  logic [PLEN-1:0]                 bpu2ifu_predicted_pc_i,
   output logic                            ifu2icache_req_valid_o,
   input  logic                            icache2ifu_req_ready_i,
   output logic [PLEN-1:0]                 ifu2icache_req_addr_o,
   input  logic                            icache2ifu_rsp_valid_i,
   input  logic [INSTR_PER_FETCH*ILEN-1:0] icache2ifu_rsp_data_i,
   output logic                            flush_icache_o,
   output logic                            ifu_ibuffer_rsp_valid_o,
   input  logic                            ibuffer_ifu_rsp_ready_i,
   output logic [PLEN-1:0]                 ifu_ibuffer_rsp_pc_o,
   output logic [INSTR_PER_FETCH*ILEN-1:0] ifu_ibuffer_rsp_data_o,
   input  logic                            flush_i,
   input  logic [PLEN-1:0]                 redirect_pc_i
`ifdef IFU_FETCH_PERF_EN
   ,
   output logic [31:0]                     perf_group_cnt_o,
   output logic [31:0]                     perf_drop_cnt_o
`endif
);

   localparam int c_PTR_W = $clog2(MAX_INFLIGHT);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam int c_DW    = INSTR_PER_FETCH * ILEN;
   localparam logic [c_CNT_W:0] c_MAX_OCC = (c_CNT_W+1)'(MAX_INFLIGHT);

   logic [PLEN-1:0]         r_pc;
   logic [PLEN-1:0]         r_pc_q   [MAX_INFLIGHT];
   logic [c_DW-1:0]         r_data_q [MAX_INFLIGHT];
   logic [MAX_INFLIGHT-1:0] r_done;
   logic [c_PTR_W-1:0]      r_head, r_rsp_ptr, r_tail;
   logic [c_CNT_W-1:0]      r_count;
   // r_pend: live entries still waiting for their ICache response
   logic [c_CNT_W-1:0]      r_pend;
   logic [c_CNT_W-1:0]      r_drop;

   logic [c_CNT_W:0] w_occ;
   logic             w_req_valid, w_req_fire;
   logic             w_rsp_acc, w_rsp_drop;
   logic             w_out_valid, w_deq;

   assign w_occ       = {1'b0, r_count} + {1'b0, r_drop};
   assign w_req_valid = !flush_i && (w_occ < c_MAX_OCC);
   assign w_req_fire  = w_req_valid && icache2ifu_req_ready_i;
   assign w_rsp_acc   = icache2ifu_rsp_valid_i && (r_drop == '0) && !flush_i;
   assign w_rsp_drop  = icache2ifu_rsp_valid_i && ((r_drop != '0) || flush_i);
   assign w_out_valid = r_done[r_head] && (r_count != '0) && !flush_i;
   assign w_deq       = w_out_valid && ibuffer_ifu_rsp_ready_i;

   assign ifu2bpu_pc_o            = r_pc;
   assign ifu2icache_req_addr_o   = r_pc;
   assign ifu2icache_req_valid_o  = w_req_valid;
   assign flush_icache_o          = flush_i;
   assign ifu_ibuffer_rsp_valid_o = w_out_valid;
   assign ifu_ibuffer_rsp_pc_o    = r_pc_q[r_head];
   assign ifu_ibuffer_rsp_data_o  = r_data_q[r_head];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc      <= RESET_PC;
         r_done    <= '0;
         r_head    <= '0;
         r_rsp_ptr <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_pend    <= '0;
         r_drop    <= '0;
         for (int i = 0; i < MAX_INFLIGHT; i++) begin
            r_pc_q[i]   <= '0;
            r_data_q[i] <= '0;
         end
      end else if (flush_i) begin
         // Every outstanding live request turns into a response to be dropped;
         // a response landing in this cycle is consumed here.
         r_pc      <= redirect_pc_i;
         r_done    <= '0;
         r_head    <= '0;
         r_rsp_ptr <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_pend    <= '0;
         r_drop    <= r_drop + r_pend - c_CNT_W'(icache2ifu_rsp_valid_i);
      end else begin
         if (w_req_fire) begin
            r_pc_q[r_tail] <= r_pc;
            r_pc           <= bpu2ifu_predicted_pc_i;
            r_tail         <= r_tail + c_PTR_W'(1);
         end
         if (w_deq) begin
            r_done[r_head] <= 1'b0;
            r_head         <= r_head + c_PTR_W'(1);
         end
         if (w_rsp_acc) begin
            r_data_q[r_rsp_ptr] <= icache2ifu_rsp_data_i;
            r_done[r_rsp_ptr]   <= 1'b1;
            r_rsp_ptr           <= r_rsp_ptr + c_PTR_W'(1);
         end
         if (w_rsp_drop)
            r_drop <= r_drop - c_CNT_W'(1);
         if (w_req_fire && !w_deq)
            r_count <= r_count + c_CNT_W'(1);
         else if (!w_req_fire && w_deq)
            r_count <= r_count - c_CNT_W'(1);
         if (w_req_fire && !w_rsp_acc)
            r_pend <= r_pend + c_CNT_W'(1);
         else if (!w_req_fire && w_rsp_acc)
            r_pend <= r_pend - c_CNT_W'(1);
      end
   end

`ifdef IFU_FETCH_PERF_EN
   logic [31:0] r_perf_group, r_perf_drop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_group <= '0;
         r_perf_drop  <= '0;
      end else begin
         if (w_deq)
            r_perf_group <= r_perf_group + 32'd1;
         if (w_rsp_drop)
            r_perf_drop <= r_perf_drop + 32'd1;
      end
   end

   assign perf_group_cnt_o = r_perf_group;
   assign perf_drop_cnt_o  = r_perf_drop;
`endif

endmodule
`default_nettype wire
